// File: rtl/pe_mac_seq.sv
// pe_mac_seq: job sequencer and wide accumulator for the PE multiply/adder-tree datapath.
// Takes one job config, streams LEN operand pairs to the datapath and accumulates its sums.
//
// Ports
//  i_clk, i_rst                  clock (rising edge), async active-low reset
//  i_cfg_*  / o_cfg_ready        job config handshake (mode, signedness, beat count)
//  i_pix_valid / o_pix_ready     operand pair handshake (i_ipix, i_wpix)
//  o_ctl_* / o_ctl_mask          datapath control, held for the whole job
//  o_ipix, o_wpix / i_sum        registered operands out, combinational sum back
//  o_acc_valid / i_acc_ready     result handshake (o_acc, o_ovf)
//  o_busy                        sequencer not idle
module pe_mac_seq #(
  parameter int DWD    = 16,
  parameter int MULTSZ = 4,
  parameter int AUODWD = 16,
  parameter int ACCWD  = 24,
  parameter int CNTWD  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [2:0]              i_cfg_mode,
  input  logic                    i_cfg_inumt,
  input  logic                    i_cfg_wnumt,
  input  logic [CNTWD-1:0]        i_cfg_len,
  input  logic                    i_pix_valid,
  output logic                    o_pix_ready,
  input  logic [DWD-1:0]          i_ipix,
  input  logic [DWD-1:0]          i_wpix,
  output logic [2:0]              o_ctl_mode,
  output logic                    o_ctl_inumt,
  output logic                    o_ctl_wnumt,
  output logic [MULTSZ*DWD-1:0]   o_ctl_mask,
  output logic [DWD-1:0]          o_ipix,
  output logic [DWD-1:0]          o_wpix,
  input  logic [AUODWD-1:0]       i_sum,
  output logic                    o_acc_valid,
  input  logic                    i_acc_ready,
  output logic [ACCWD-1:0]        o_acc,
  output logic                    o_ovf,
  output logic                    o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [CNTWD:0] ONE = {{CNTWD{1'b0}}, 1'b1};

  state_t state;

  // One extra bit so that a length of 0 can stand for 2**CNTWD beats.
  logic [CNTWD:0]           remaining;
  logic                     v;
  logic signed [ACCWD-1:0]  acc;
  logic signed [ACCWD-1:0]  addend;
  logic signed [ACCWD-1:0]  acc_sum;
  logic                     ovf;
  logic                     add_ovf;
  logic                     cfg_hs;
  logic                     pix_hs;
  logic                     legal;
  logic [MULTSZ*DWD-1:0]    mask_new;

  assign cfg_hs  = i_cfg_valid & o_cfg_ready;
  assign pix_hs  = i_pix_valid & o_pix_ready;
  assign legal   = (i_cfg_mode <= 3'd4);

  assign addend  = ACCWD'($signed(i_sum));
  assign acc_sum = acc + addend;
  assign add_ovf = (acc[ACCWD-1] == addend[ACCWD-1]) &&
                   (acc_sum[ACCWD-1] != acc[ACCWD-1]);

  always_comb begin
    mask_new = '0;
    unique case (1'b1)
      (i_cfg_mode == 3'd0),
      (i_cfg_mode == 3'd1): mask_new[0*DWD +: DWD] = '1;
      (i_cfg_mode == 3'd2): mask_new[1*DWD +: DWD] = '1;
      (i_cfg_mode == 3'd3): mask_new[2*DWD +: DWD] = '1;
      (i_cfg_mode == 3'd4): mask_new[3*DWD +: DWD] = '1;
      default:              mask_new = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      remaining   <= '0;
      v           <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      o_cfg_ready <= 1'b0;
      o_pix_ready <= 1'b0;
      o_ctl_mode  <= '0;
      o_ctl_inumt <= 1'b0;
      o_ctl_wnumt <= 1'b0;
      o_ctl_mask  <= '0;
      o_ipix      <= '0;
      o_wpix      <= '0;
      o_acc_valid <= 1'b0;
      o_acc       <= '0;
      o_ovf       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_cfg_ready <= 1'b1;
          // Illegal modes are consumed here and simply dropped.
          if (cfg_hs && legal) begin
            o_ctl_mode  <= i_cfg_mode;
            o_ctl_inumt <= i_cfg_inumt;
            o_ctl_wnumt <= i_cfg_wnumt;
            o_ctl_mask  <= mask_new;
            acc         <= '0;
            ovf         <= 1'b0;
            o_ovf       <= 1'b0;
            remaining   <= {(i_cfg_len == '0), i_cfg_len};
            v           <= 1'b0;
            o_cfg_ready <= 1'b0;
            o_pix_ready <= 1'b1;
            o_busy      <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          // i_sum belongs to the operands registered on the previous edge.
          if (v) begin
            acc <= acc_sum;
            ovf <= ovf | add_ovf;
          end
          v <= pix_hs;
          if (pix_hs) begin
            o_ipix    <= i_ipix;
            o_wpix    <= i_wpix;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              o_pix_ready <= 1'b0;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // First cycle folds in the last beat, second publishes the result.
          if (v) begin
            acc <= acc_sum;
            ovf <= ovf | add_ovf;
            v   <= 1'b0;
          end else begin
            o_acc       <= acc;
            o_ovf       <= ovf;
            o_acc_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (i_acc_ready) begin
            o_acc_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
